// File: rtl/seq_hit_window_counter_pkg.sv
// Shared definitions for the windowed hit counter.
// Holds the FSM state encoding and the default parameter values used by the top.
package seq_hit_window_counter_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StCount = 1'b1
  } state_e;

  localparam int unsigned DefCntW   = 8;
  localparam int unsigned DefWinW   = 16;
  localparam int unsigned DefWindow = 100;
  localparam int unsigned DefDropW  = 8;

endpackage

// File: rtl/seq_hit_window_counter_if.sv
// Report port of the windowed hit counter: one window total per valid/ready transfer.
//   rpt_count  window hit total
//   rpt_sat    total saturated during the window
//   rpt_valid  report available
//   rpt_ready  consumer accepts when rpt_valid & rpt_ready
// master = counter side, slave = consumer side.
interface seq_hit_window_counter_if #(
  parameter int unsigned CNT_W = 8
);

  logic [CNT_W-1:0] rpt_count;
  logic             rpt_sat;
  logic             rpt_valid;
  logic             rpt_ready;

  modport master (
    output rpt_count,
    output rpt_sat,
    output rpt_valid,
    input  rpt_ready
  );

  modport slave (
    input  rpt_count,
    input  rpt_sat,
    input  rpt_valid,
    output rpt_ready
  );

endinterface

// File: rtl/seq_hit_window_counter_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk  clock
//   inc  count up by one unless already at all-ones
//   clr  clear to zero (wins over inc)
//   q    current count
//   sat  count is at its maximum
module seq_hit_window_counter_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q,
  output logic         sat
);

  logic [W-1:0] q_d;

  assign sat = &q;

  always_comb begin
    q_d = q;
    if (clr) begin
      q_d = '0;
    end else if (inc && !sat) begin
      q_d = q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    q <= q_d;
  end

endmodule

// File: rtl/seq_hit_window_counter.sv
// Counts sequence-detector match pulses over back-to-back windows of WINDOW cycles and
// offers each window total on a valid/ready report port. Windows that end while a report
// is still pending are discarded and counted in drop_cnt.
//   clk       clock, all logic on posedge
//   clr_n     synchronous active-low reset
//   hit_in    match pulse, sampled every cycle
//   enable    1 = run windows, 0 = idle (partial window discarded)
//   rpt       report port (master side)
//   drop_cnt  saturating count of windows lost to back-pressure
//   busy      high while counting
module seq_hit_window_counter
  import seq_hit_window_counter_pkg::*;
#(
  parameter int unsigned CNT_W  = DefCntW,
  parameter int unsigned WIN_W  = DefWinW,
  parameter int unsigned WINDOW = DefWindow,
  parameter int unsigned DROP_W = DefDropW
) (
  input  logic                   clk,
  input  logic                   clr_n,
  input  logic                   hit_in,
  input  logic                   enable,
  seq_hit_window_counter_if.master rpt,
  output logic [DROP_W-1:0]      drop_cnt,
  output logic                   busy
);

  state_e             state_q, state_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic               win_end;

  logic [CNT_W-1:0]   hit_cnt;
  logic               hit_sat;
  logic               hit_clr;
  logic [CNT_W-1:0]   hit_final;

  logic               drop_inc;

  logic [CNT_W-1:0]   rpt_count_q, rpt_count_d;
  logic               rpt_sat_q, rpt_sat_d;
  logic               rpt_valid_q, rpt_valid_d;
  logic               accept;

  assign win_end = (state_q == StCount) && (win_cnt_q == WIN_W'(WINDOW - 1));

  // FSM next state and busy flag
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StCount;
      end
      StCount: begin
        busy = 1'b1;
        if (!enable) state_d = StIdle;
      end
    endcase
  end

  // Window position: wraps to 0 at window end, held at 0 outside a running window
  always_comb begin
    win_cnt_d = '0;
    if (state_q == StCount && enable && !win_end) begin
      win_cnt_d = win_cnt_q + WIN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q   <= StIdle;
      win_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      win_cnt_q <= win_cnt_d;
    end
  end

  // Hit counter restarts after every window end and whenever the window is not running
  assign hit_clr = !clr_n || (state_q != StCount) || win_end || !enable;

  seq_hit_window_counter_sat_counter #(
    .W (CNT_W)
  ) u_hit_cnt (
    .clk (clk),
    .inc (hit_in),
    .clr (hit_clr),
    .q   (hit_cnt),
    .sat (hit_sat)
  );

  // Window total must include the hit arriving on the last window cycle
  assign hit_final = (hit_in && !hit_sat) ? hit_cnt + CNT_W'(1) : hit_cnt;

  assign accept   = rpt_valid_q && rpt.rpt_ready;
  assign drop_inc = win_end && rpt_valid_q && !rpt.rpt_ready;

  seq_hit_window_counter_sat_counter #(
    .W (DROP_W)
  ) u_drop_cnt (
    .clk (clk),
    .inc (drop_inc),
    .clr (!clr_n),
    .q   (drop_cnt),
    .sat ()
  );

  // Report register: a new total may replace the old one only when the slot frees this cycle
  always_comb begin
    rpt_count_d = rpt_count_q;
    rpt_sat_d   = rpt_sat_q;
    rpt_valid_d = rpt_valid_q;
    if (win_end && (!rpt_valid_q || rpt.rpt_ready)) begin
      rpt_count_d = hit_final;
      rpt_sat_d   = &hit_final;
      rpt_valid_d = 1'b1;
    end else if (accept) begin
      rpt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      rpt_count_q <= '0;
      rpt_sat_q   <= 1'b0;
      rpt_valid_q <= 1'b0;
    end else begin
      rpt_count_q <= rpt_count_d;
      rpt_sat_q   <= rpt_sat_d;
      rpt_valid_q <= rpt_valid_d;
    end
  end

  assign rpt.rpt_count = rpt_count_q;
  assign rpt.rpt_sat   = rpt_sat_q;
  assign rpt.rpt_valid = rpt_valid_q;

endmodule

// File: tb/tb_seq_hit_window_counter.sv
// Directed bench for seq_hit_window_counter with WINDOW=8. A CNT_W=8 instance covers
// reset, basic counting, back-pressure, simultaneous accept and abort; a CNT_W=2 instance
// covers saturation. Expected reports are queued when a window is driven and compared
// whenever the main DUT completes a valid/ready transfer.
module tb_seq_hit_window_counter;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       hit_in;
  logic       enable;
  logic [7:0] drop_cnt;
  logic       busy;

  logic       s_hit;
  logic       s_enable;
  logic [7:0] s_drop;
  logic       s_busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [7:0] count;
    logic       sat;
  } rpt_t;

  rpt_t exp_q[$];
  rpt_t exp_r;

  seq_hit_window_counter_if #(.CNT_W(8)) rpt_if ();
  seq_hit_window_counter_if #(.CNT_W(2)) s_if ();

  seq_hit_window_counter #(
    .CNT_W  (8),
    .WIN_W  (16),
    .WINDOW (8),
    .DROP_W (8)
  ) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .hit_in   (hit_in),
    .enable   (enable),
    .rpt      (rpt_if),
    .drop_cnt (drop_cnt),
    .busy     (busy)
  );

  seq_hit_window_counter #(
    .CNT_W  (2),
    .WIN_W  (16),
    .WINDOW (8),
    .DROP_W (8)
  ) dut_sat (
    .clk      (clk),
    .clr_n    (clr_n),
    .hit_in   (s_hit),
    .enable   (s_enable),
    .rpt      (s_if),
    .drop_cnt (s_drop),
    .busy     (s_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one full window; bit c of mask is hit_in on window cycle c
  task automatic run_window(input logic [7:0] mask);
    for (int c = 0; c < 8; c++) begin
      hit_in = mask[c];
      step();
    end
    hit_in = 1'b0;
  endtask

  // Scoreboard: compare every accepted report against the queued expectation
  always @(negedge clk) begin
    if (clr_n === 1'b1 && rpt_if.rpt_valid === 1'b1 && rpt_if.rpt_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL report_unexpected: observed count %0d expected no report",
               rpt_if.rpt_count);
      end else begin
        exp_r = exp_q.pop_front();
        check("report_count", 32'(rpt_if.rpt_count), 32'(exp_r.count));
        check("report_sat", 32'(rpt_if.rpt_sat), 32'(exp_r.sat));
      end
    end
  end

  initial begin
    clr_n            = 1'b0;
    hit_in           = 1'b0;
    enable           = 1'b0;
    rpt_if.rpt_ready = 1'b0;
    s_hit            = 1'b0;
    s_enable         = 1'b0;
    s_if.rpt_ready   = 1'b0;
    step();
    step();
    clr_n = 1'b1;
    check("reset_valid", 32'(rpt_if.rpt_valid), 0);
    check("reset_count", 32'(rpt_if.rpt_count), 0);
    check("reset_drop", 32'(drop_cnt), 0);
    check("reset_busy", 32'(busy), 0);

    // Basic: hits on cycles 1,4,7, then a second window with no gap
    rpt_if.rpt_ready = 1'b1;
    enable           = 1'b1;
    step();
    check("basic_busy", 32'(busy), 1);
    exp_q.push_back('{count: 8'd3, sat: 1'b0});
    run_window(8'b1001_0010);
    check("basic_valid", 32'(rpt_if.rpt_valid), 1);
    check("basic_count", 32'(rpt_if.rpt_count), 3);
    check("basic_sat", 32'(rpt_if.rpt_sat), 0);
    exp_q.push_back('{count: 8'd1, sat: 1'b0});
    run_window(8'b0000_0001);
    check("nogap_valid", 32'(rpt_if.rpt_valid), 1);
    check("nogap_count", 32'(rpt_if.rpt_count), 1);
    enable = 1'b0;
    step();
    check("basic_valid_drop", 32'(rpt_if.rpt_valid), 0);
    check("basic_idle", 32'(busy), 0);
    step();

    // Saturation on the CNT_W=2 instance
    s_if.rpt_ready = 1'b1;
    s_enable       = 1'b1;
    step();
    for (int c = 0; c < 8; c++) begin
      s_hit = 1'b1;
      step();
    end
    s_hit    = 1'b0;
    s_enable = 1'b0;
    check("sat_valid", 32'(s_if.rpt_valid), 1);
    check("sat_count", 32'(s_if.rpt_count), 3);
    check("sat_flag", 32'(s_if.rpt_sat), 1);
    step();
    check("sat_accepted", 32'(s_if.rpt_valid), 0);

    // Back-pressure over three windows with 2/5/1 hits
    rpt_if.rpt_ready = 1'b0;
    enable           = 1'b1;
    step();
    exp_q.push_back('{count: 8'd2, sat: 1'b0});
    run_window(8'b0000_0011);
    check("bp_w1_count", 32'(rpt_if.rpt_count), 2);
    check("bp_w1_drop", 32'(drop_cnt), 0);
    run_window(8'b0001_1111);
    check("bp_w2_count", 32'(rpt_if.rpt_count), 2);
    check("bp_w2_drop", 32'(drop_cnt), 1);
    run_window(8'b1000_0000);
    check("bp_w3_count", 32'(rpt_if.rpt_count), 2);
    check("bp_w3_valid", 32'(rpt_if.rpt_valid), 1);
    check("bp_w3_drop", 32'(drop_cnt), 2);
    enable           = 1'b0;
    rpt_if.rpt_ready = 1'b1;
    step();
    check("bp_accept_valid", 32'(rpt_if.rpt_valid), 0);
    check("bp_accept_drop", 32'(drop_cnt), 2);
    check("bp_idle", 32'(busy), 0);
    step();

    // Accept on the window-end cycle replaces the report without a drop
    rpt_if.rpt_ready = 1'b0;
    enable           = 1'b1;
    step();
    exp_q.push_back('{count: 8'd2, sat: 1'b0});
    run_window(8'b0010_0100);
    check("sim_old_count", 32'(rpt_if.rpt_count), 2);
    exp_q.push_back('{count: 8'd6, sat: 1'b0});
    for (int c = 0; c < 8; c++) begin
      hit_in           = (c >= 2) ? 1'b1 : 1'b0;
      rpt_if.rpt_ready = (c == 7) ? 1'b1 : 1'b0;
      step();
    end
    hit_in = 1'b0;
    check("sim_valid", 32'(rpt_if.rpt_valid), 1);
    check("sim_count", 32'(rpt_if.rpt_count), 6);
    check("sim_drop", 32'(drop_cnt), 2);
    enable = 1'b0;
    step();
    check("sim_accept_valid", 32'(rpt_if.rpt_valid), 0);
    step();

    // Abort at window cycle 5 after 3 hits, then a fresh window
    enable = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      hit_in = (c % 2 == 0) ? 1'b1 : 1'b0;
      step();
    end
    hit_in = 1'b0;
    enable = 1'b0;
    step();
    check("abort_idle", 32'(busy), 0);
    step();
    step();
    check("abort_no_report", 32'(rpt_if.rpt_valid), 0);
    exp_q.push_back('{count: 8'd1, sat: 1'b0});
    enable = 1'b1;
    step();
    run_window(8'b0100_0000);
    check("restart_valid", 32'(rpt_if.rpt_valid), 1);
    check("restart_count", 32'(rpt_if.rpt_count), 1);
    enable = 1'b0;
    step();
    step();

    // Mid-run reset with a pending report and a nonzero drop count
    rpt_if.rpt_ready = 1'b0;
    enable           = 1'b1;
    step();
    run_window(8'b0000_0001);
    run_window(8'b0000_0000);
    check("pre_reset_drop", 32'(drop_cnt), 3);
    check("pre_reset_valid", 32'(rpt_if.rpt_valid), 1);
    hit_in = 1'b1;
    step();
    step();
    step();
    clr_n = 1'b0;
    step();
    step();
    check("midreset_valid", 32'(rpt_if.rpt_valid), 0);
    check("midreset_count", 32'(rpt_if.rpt_count), 0);
    check("midreset_drop", 32'(drop_cnt), 0);
    check("midreset_busy", 32'(busy), 0);
    hit_in = 1'b0;
    enable = 1'b0;
    clr_n  = 1'b1;
    step();
    check("reports_outstanding", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
